// File: rtl/riscv_mmio_timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register offsets,
// CTRL/STATUS bit positions, reset values and the byte-strobe merge helper.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_mmio_timer_pkg;

  localparam logic [2:0] TMR_MTIME_LO    = 3'd0;
  localparam logic [2:0] TMR_MTIME_HI    = 3'd1;
  localparam logic [2:0] TMR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] TMR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] TMR_CTRL        = 3'd4;
  localparam logic [2:0] TMR_STATUS      = 3'd5;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_IE_BIT      = 1;
  localparam int CTRL_PRESC_LSB   = 8;
  localparam int STATUS_MATCH_BIT = 0;
  localparam int STATUS_WRAP_BIT  = 1;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/riscv_tmr_prescaler.sv
// Prescaler: counts 0..PRESC while enabled and emits a one-cycle tick on PRESC.
module riscv_tmr_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_en,
  input  logic [PRESC_W-1:0] i_presc,
  input  logic               i_clr,
  output logic               o_tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  // A CTRL write restarts the count, so no tick is issued on that edge.
  assign o_tick = i_en & ~i_clr & (cnt_q == i_presc);

  // Next count: wrap on tick, hold at zero when disabled or cleared.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!i_en || i_clr || o_tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/riscv_mmio_timer.sv
// Memory-mapped machine timer: 64-bit prescaled mtime, mtimecmp, CTRL,
// sticky WRAP status and a registered level interrupt.
module riscv_mmio_timer
  import riscv_mmio_timer_pkg::*;
#(
  parameter logic [`XLEN-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int               PRESC_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [`XLEN-1:0] i_addr,
  input  logic             i_wr_en,
  input  logic [3:0]       i_strb,
  input  logic [`XLEN-1:0] i_wr_data,
  output logic [`XLEN-1:0] o_rd_data,
  output logic             o_hit,
  output logic             o_irq
);

  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic               en_q, en_d;
  logic               ie_q, ie_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               wrap_q, wrap_d;
  logic               irq_q, irq_d;

  logic [2:0]         offset;
  logic               wr;
  logic               ctrl_wr;
  logic               tick;
  logic               match;
  logic [31:0]        ctrl_rd;
  logic               unused_addr;

  assign unused_addr = ^i_addr[1:0];
  assign offset      = i_addr[4:2];
  assign o_hit       = (i_addr[`XLEN-1:5] == BASE_ADDR[`XLEN-1:5]);
  assign wr          = i_wr_en & o_hit & (|i_strb);
  assign ctrl_wr     = wr & (offset == TMR_CTRL);
  assign match       = (mtime_q >= mtimecmp_q);
  assign o_irq       = irq_q;

  riscv_tmr_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_en    (en_q),
    .i_presc (presc_q),
    .i_clr   (ctrl_wr),
    .o_tick  (tick)
  );

  // CTRL read view: unimplemented bits read as zero.
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN_BIT] = en_q;
    ctrl_rd[CTRL_IE_BIT] = ie_q;
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_W] = presc_q;
  end

  // Combinational read mux, zero when the block is not selected.
  always_comb begin
    o_rd_data = '0;
    if (o_hit) begin
      case (offset)
        TMR_MTIME_LO:    o_rd_data = mtime_q[31:0];
        TMR_MTIME_HI:    o_rd_data = mtime_q[63:32];
        TMR_MTIMECMP_LO: o_rd_data = mtimecmp_q[31:0];
        TMR_MTIMECMP_HI: o_rd_data = mtimecmp_q[63:32];
        TMR_CTRL:        o_rd_data = ctrl_rd;
        TMR_STATUS: begin
          o_rd_data[STATUS_MATCH_BIT] = match;
          o_rd_data[STATUS_WRAP_BIT]  = wrap_q;
        end
        default:         o_rd_data = '0;
      endcase
    end
  end

  // Next-state: software writes beat the tick increment; a wrap beats W1C.
  always_comb begin
    mtime_d    = mtime_q + {63'd0, tick};
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    ie_d       = ie_q;
    presc_d    = presc_q;
    wrap_d     = wrap_q;
    if (wr) begin
      case (offset)
        TMR_MTIME_LO:    mtime_d = {mtime_q[63:32], strb_merge(mtime_q[31:0], i_wr_data, i_strb)};
        TMR_MTIME_HI:    mtime_d = {strb_merge(mtime_q[63:32], i_wr_data, i_strb), mtime_q[31:0]};
        TMR_MTIMECMP_LO: mtimecmp_d[31:0]  = strb_merge(mtimecmp_q[31:0], i_wr_data, i_strb);
        TMR_MTIMECMP_HI: mtimecmp_d[63:32] = strb_merge(mtimecmp_q[63:32], i_wr_data, i_strb);
        TMR_CTRL: begin
          if (i_strb[0]) begin
            en_d = i_wr_data[CTRL_EN_BIT];
            ie_d = i_wr_data[CTRL_IE_BIT];
          end
          for (int i = 0; i < PRESC_W; i++) begin
            if (i_strb[(CTRL_PRESC_LSB + i) / 8]) presc_d[i] = i_wr_data[CTRL_PRESC_LSB + i];
          end
        end
        TMR_STATUS: begin
          if (i_strb[0] && i_wr_data[STATUS_WRAP_BIT]) wrap_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (tick && (&mtime_q)) wrap_d = 1'b1;
    irq_d = match & ie_q;
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      presc_q    <= '0;
      wrap_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      presc_q    <= presc_d;
      wrap_q     <= wrap_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_riscv_mmio_timer.sv
// Directed bench for riscv_mmio_timer with hand-computed expectations.
module tb_riscv_mmio_timer;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk;
  logic        rstn;
  logic [31:0] addr;
  logic        wr_en;
  logic [3:0]  strb;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        hit;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  riscv_mmio_timer #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_addr    (addr),
    .i_wr_en   (wr_en),
    .i_strb    (strb),
    .i_wr_data (wr_data),
    .o_rd_data (rd_data),
    .o_hit     (hit),
    .o_irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive a write on the next rising edge, return 1 time unit after it.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    addr = a; wr_data = d; strb = s; wr_en = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1 chk(tag, rd_data, exp);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; addr = BASE; wr_en = 1'b0; strb = 4'h0; wr_data = '0;
    #22 rstn = 1'b1;

    // Reset state
    #1 chk("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_mtime_lo", BASE + 32'h00, 32'h0);
    rd_chk("rst_cmp_lo",   BASE + 32'h08, 32'hFFFF_FFFF);
    rd_chk("rst_cmp_hi",   BASE + 32'h0C, 32'hFFFF_FFFF);
    rd_chk("rst_ctrl",     BASE + 32'h10, 32'h0);
    rd_chk("rst_status",   BASE + 32'h14, 32'h0);
    edges(100);
    rd_chk("idle_mtime", BASE + 32'h00, 32'h0);

    // Prescaler 3: one tick every 4 cycles
    bus_wr(BASE + 32'h10, 32'h0000_0301, 4'hF);
    rd_chk("ctrl_rb", BASE + 32'h10, 32'h0000_0301);
    edges(3);
    rd_chk("presc_3cyc", BASE + 32'h00, 32'd0);
    edges(1);
    rd_chk("presc_4cyc", BASE + 32'h00, 32'd1);
    edges(96);
    rd_chk("presc_100cyc", BASE + 32'h00, 32'd25);
    bus_wr(BASE + 32'h10, 32'h0, 4'hF);
    edges(20);
    rd_chk("hold_en0", BASE + 32'h00, 32'd25);

    // Wrap and sticky W1C status
    bus_wr(BASE + 32'h00, 32'hFFFF_FFFE, 4'hF);
    bus_wr(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF);
    bus_wr(BASE + 32'h10, 32'h1, 4'hF);
    edges(1);
    rd_chk("pre_wrap_lo", BASE + 32'h00, 32'hFFFF_FFFF);
    edges(1);
    rd_chk("wrap_lo", BASE + 32'h00, 32'h0);
    rd_chk("wrap_hi", BASE + 32'h04, 32'h0);
    rd_chk("wrap_status", BASE + 32'h14, 32'h2);
    bus_wr(BASE + 32'h10, 32'h0, 4'hF);
    rd_chk("wrap_status_hold", BASE + 32'h14, 32'h2);
    bus_wr(BASE + 32'h14, 32'h2, 4'hF);
    rd_chk("w1c_status", BASE + 32'h14, 32'h0);

    // Compare match and interrupt latency
    bus_wr(BASE + 32'h00, 32'h0, 4'hF);
    bus_wr(BASE + 32'h08, 32'd10, 4'hF);
    bus_wr(BASE + 32'h0C, 32'h0, 4'hF);
    rd_chk("cmp_no_match", BASE + 32'h14, 32'h0);
    bus_wr(BASE + 32'h10, 32'h3, 4'hF);
    edges(10);
    rd_chk("mtime_at_10", BASE + 32'h00, 32'd10);
    chk("irq_not_yet", {31'd0, irq}, 32'd0);
    edges(1);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    bus_wr(BASE + 32'h08, 32'd1000, 4'hF);
    chk("irq_still_high", {31'd0, irq}, 32'd1);
    edges(1);
    chk("irq_drop", {31'd0, irq}, 32'd0);
    bus_wr(BASE + 32'h10, 32'h0, 4'hF);

    // Byte strobes
    bus_wr(BASE + 32'h08, 32'hFFFF_FFFF, 4'hF);
    bus_wr(BASE + 32'h08, 32'h00AB_0000, 4'b0100);
    rd_chk("strb_lane2", BASE + 32'h08, 32'hFFAB_FFFF);
    bus_wr(BASE + 32'h08, 32'h1234_5678, 4'b0000);
    rd_chk("strb_none", BASE + 32'h08, 32'hFFAB_FFFF);

    // Software write beats tick on the same edge
    bus_wr(BASE + 32'h10, 32'h1, 4'hF);
    edges(3);
    bus_wr(BASE + 32'h00, 32'h55, 4'hF);
    rd_chk("collide_lo", BASE + 32'h00, 32'h55);
    rd_chk("collide_hi", BASE + 32'h04, 32'h0);
    bus_wr(BASE + 32'h10, 32'h0, 4'hF);
    rd_chk("stopped_lo", BASE + 32'h00, 32'h55);

    // Decode miss
    @(negedge clk);
    addr = BASE + 32'h40; wr_data = 32'hDEAD_BEEF; strb = 4'hF; wr_en = 1'b1;
    #1 chk("miss_hit", {31'd0, hit}, 32'd0);
    chk("miss_rdata", rd_data, 32'h0);
    @(posedge clk);
    #1 addr = BASE + 32'h50; wr_data = 32'h0000_0303;
    @(posedge clk);
    #1 wr_en = 1'b0;
    rd_chk("miss_mtime", BASE + 32'h00, 32'h55);
    chk("hit_base", {31'd0, hit}, 32'd1);
    rd_chk("miss_ctrl", BASE + 32'h10, 32'h0);

    // Asynchronous reset mid-count
    bus_wr(BASE + 32'h08, 32'h0, 4'hF);
    bus_wr(BASE + 32'h0C, 32'h0, 4'hF);
    bus_wr(BASE + 32'h10, 32'h3, 4'hF);
    edges(3);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    #1 rstn = 1'b0;
    #1 chk("async_rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("async_rst_mtime", BASE + 32'h00, 32'h0);
    rd_chk("async_rst_cmp", BASE + 32'h0C, 32'hFFFF_FFFF);
    rd_chk("async_rst_ctrl", BASE + 32'h10, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    edges(5);
    rd_chk("post_rst_mtime", BASE + 32'h00, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_mmio_timer.md
Name: riscv_mmio_timer

Overview:
- Memory-mapped machine timer. It is the responder on the CPU data-memory port: address, write enable, byte strobe, write data in; read data out.
- Sits beside the data memory in the top level. Address decode on BASE_ADDR selects it; the top-level read mux uses o_hit.
- Provides a prescaled 64-bit free-running counter (mtime), a 64-bit compare register (mtimecmp), a control register, a sticky status register and a level timer interrupt.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte base address of the block; must be 32-byte aligned.
- PRESC_W, 8, width of the prescaler field and prescaler counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_addr  in  `XLEN  byte address from the CPU data port.
- i_wr_en  in  1  write request, qualified by o_hit.
- i_strb  in  4  byte-lane strobes; bit n enables byte n.
- i_wr_data  in  `XLEN  write data.
- o_rd_data  out  `XLEN  read data, combinational from i_addr.
- o_hit  out  1  high when i_addr[`XLEN-1:5] == BASE_ADDR[`XLEN-1:5].
- o_irq  out  1  timer interrupt, registered, level.

Behaviour:
- Register map. Offset is i_addr[4:2]; i_addr[1:0] is ignored.
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 CTRL: bit0 EN, bit1 IE, bits[8+PRESC_W-1:8] PRESC, others read 0
  - 5 STATUS: bit0 MATCH (read-only), bit1 WRAP (sticky, write-1-to-clear)
  - 6, 7 unmapped: read 0, writes ignored
- Reset values:
  - mtime = 0, mtimecmp = all ones, CTRL = 0, WRAP = 0
  - prescaler counter = 0, o_irq = 0
  - With these values MATCH = 0 after reset.
- Reads:
  - o_rd_data is valid in the same cycle as i_addr, with no side effects. This matches the data memory's asynchronous read.
  - When o_hit = 0, o_rd_data = 0.
- Writes:
  - Occur on the clock edge when i_wr_en & o_hit.
  - Each byte lane is updated only where i_strb is set; other bytes keep their value.
  - i_strb = 0 is a no-op.
- Prescaler:
  - When EN = 1, the prescaler counter counts 0..PRESC and a tick is generated when it equals PRESC. The counter returns to 0 on tick.
  - PRESC = 0 therefore gives a tick every cycle.
  - When EN = 0, the counter holds at 0 and mtime holds.
  - A write to CTRL resets the prescaler counter to 0 on that edge.
- mtime increments by 1 on each tick, 64-bit, wrapping from all ones to 0.
  - On wrap, WRAP is set on that same edge.
- Simultaneous events:
  - A software write to MTIME_LO/HI on the tick edge wins: the written bytes are loaded and the increment is discarded for the whole 64 bits that cycle.
  - A W1C write to WRAP on the same edge as a wrap leaves WRAP set (set wins).
- MATCH = (mtime >= mtimecmp), an unsigned 64-bit compare on the current register values, combinational.
- o_irq is registered: o_irq <= MATCH & IE. Latency is one cycle after the edge on which mtime or mtimecmp reaches the matching value.
- o_irq is level-sensitive and deasserts one cycle after software raises mtimecmp above mtime or clears IE.
- 64-bit update order: software must write MTIMECMP_HI = all ones first, then LO, then HI. The block performs no atomicity.
- Asynchronous reset mid-operation forces all state to reset values immediately. o_irq drops without waiting for a clock edge.

Decomposition:
- Shared package/header holds:
  - register offset constants (TMR_MTIME_LO..TMR_STATUS)
  - CTRL/STATUS bit positions
  - the reset value of mtimecmp
  - `XLEN, reused as already defined
- One sub-module, riscv_tmr_prescaler: EN, PRESC and a clear input in; tick out.
- Byte-strobe merge is a small function used for each 32-bit half.

Test Plan:
- Reset, then release with no writes.
  - o_irq = 0; reading offset 0x00, 0x08, 0x0C, 0x10 gives 0, FFFFFFFF, FFFFFFFF, 0.
  - mtime stays 0 for 100 cycles.
- Write CTRL = 0x0000_0301 (EN = 1, PRESC = 3).
  - MTIME_LO reads 1 after 4 cycles and 25 after 100 cycles.
  - Then write CTRL = 0 and confirm mtime holds.
- Write MTIME_LO = 0xFFFF_FFFE, MTIME_HI = 0xFFFF_FFFF, then CTRL = 0x1 (PRESC = 0).
  - After 2 ticks mtime = 0 and STATUS = 0x2.
  - Writing STATUS = 0x2 clears it to 0x0.
- Write mtimecmp = 10, CTRL = 0x3.
  - o_irq rises exactly one cycle after mtime reaches 10.
  - Writing MTIMECMP_LO = 1000 drops o_irq one cycle later.
- Byte strobes: write MTIMECMP_LO with i_strb = 4'b0100 and data 0x00AB_0000 → reads FFABFFFF. Write with i_strb = 0 → no change.
- Collision and decode:
  - A write of MTIME_LO = 0x55 on a tick edge → reads 0x55, not 0x56.
  - Writes to i_addr = BASE_ADDR + 0x40 leave all registers unchanged, with o_hit = 0 and o_rd_data = 0.
  - Asserting i_rstn = 0 mid-count clears mtime and o_irq asynchronously.
